line_window_gen: RTL and testbench
==================================

# line_window_gen

Parametrised line-buffer and sliding-window generator for the streaming image-processing pipeline. Accepts a raster pixel stream and stores it in a ring of line buffers. Emits one KSIZE×KSIZE window per cycle to the convolution stage, with output backpressure and optional horizontal zero padding. Pulses an interrupt each time a line buffer is released, so the host DMA can push the next line.

## Interface
- DATA_W, 8, pixel width in bits
- IMG_WIDTH, 512, pixels per line; must be ≥ KSIZE
- KSIZE, 3, window size; must be odd, 3..7
- NUM_LB, KSIZE+1, number of line buffers; must be ≥ KSIZE+1
- PAD_EN, 0, 1 = zero-pad (KSIZE-1)/2 columns on each side of every line

Ports:
- axi_clk  in  1  clock; the block has one clock domain
- axi_reset_n  in  1  reset, asynchronous, active-low
- i_data_valid  in  1  input pixel valid
- i_data  in  DATA_W  input pixel, raster order
- o_data_ready  out  1  block can accept a pixel
- o_window_valid  out  1  window valid
- o_window  out  KSIZE*KSIZE*DATA_W  window; pixel (r,c) sits at bits [(r*KSIZE+c)*DATA_W +: DATA_W]; r=0 is the oldest line, c=0 is the leftmost column
- i_window_ready  in  1  downstream accepts the window
- o_intr  out  1  one-cycle pulse when a line buffer is released

## Operation
- Write side:
  - A pixel is accepted on a cycle where i_data_valid && o_data_ready.
  - Each accepted pixel is written to buffer wr_lb at column wr_col.
  - wr_col counts 0..IMG_WIDTH-1 and wraps to 0 after IMG_WIDTH-1.
  - On that wrap, wr_lb advances modulo NUM_LB and filled_lines increments.
- filled_lines is a counter in the range 0..NUM_LB.
  - A write-completion and a release in the same cycle leave it unchanged.
  - o_data_ready is registered: next value = (next filled_lines < NUM_LB).
  - When all buffers are full, input stalls; i_data is ignored while o_data_ready=0.
- Read FSM states:
  - IDLE: go to RD_LINE when filled_lines ≥ KSIZE. Reset rd_col and clear the window shift register.
  - RD_LINE: each non-stalled cycle reads column rd_col from the KSIZE buffers rd_lb..rd_lb+KSIZE-1 (mod NUM_LB) and shifts that column in as c=KSIZE-1.
    - Column sequence with PAD_EN=0: 0..IMG_WIDTH-1.
    - Column sequence with PAD_EN=1: (KSIZE-1)/2 zero columns, then 0..IMG_WIDTH-1, then (KSIZE-1)/2 zero columns.
    - Once KSIZE columns have been loaded, each further loaded column produces one window.
    - Windows per line: IMG_WIDTH-KSIZE+1 when PAD_EN=0, IMG_WIDTH when PAD_EN=1.
  - RELEASE: entered after the last window of the line is accepted. Lasts one cycle.
    - rd_lb advances by 1 modulo NUM_LB.
    - filled_lines decrements.
    - o_intr=1 for this cycle.
    - Next state is IDLE.
- Stall: when o_window_valid && !i_window_ready:
  - read address and read enable freeze;
  - the memory output register and the window hold;
  - o_window is stable until accepted.
- Vertical padding is not done in this block; upstream supplies extra lines (for example zero lines after the last image line).
- Write and read may target different buffers in the same cycle. The write buffer is never one of the KSIZE buffers being read, which NUM_LB ≥ KSIZE+1 guarantees.

## Timing
- Reset values (asynchronous): o_data_ready=0, o_window_valid=0, o_window=0, o_intr=0, state=IDLE, all counters 0.
- o_data_ready rises in the first cycle after axi_reset_n deasserts.
- Buffer read latency: 1 cycle.
- First window: let t be the cycle in which the last pixel of line KSIZE is accepted, with i_window_ready held at 1.
  - IDLE is evaluated in t+1.
  - Column 0 is read in t+2.
  - o_window_valid is first high in cycle t+KSIZE+2 (t+5 for KSIZE=3, PAD_EN=0).
- Throughput: one window per cycle while i_window_ready=1.
- Gap between lines: RELEASE + IDLE + KSIZE priming columns + 1.
- o_intr is high exactly one cycle per released line and is never asserted outside RELEASE.
- Reset asserted mid-line: all state clears immediately. Partial lines and windows are discarded; buffer contents need not be cleared.

## Test plan
- Reset check (IMG_WIDTH=8, KSIZE=3): hold reset, then release → all outputs 0 during reset; o_data_ready=1 one cycle after release; no o_window_valid or o_intr until 3 lines have been written.
- Ramp pixel value = 16*row+col, PAD_EN=0, ready=1 → first window valid at t+5 with r0={0,1,2}, r1={16,17,18}, r2={32,33,34}; 6 windows per line; o_intr pulses once per line.
- Same stream with PAD_EN=1 → 8 windows per line; the first window has c=0 equal to 0 in all rows, and c=1 equal to {0,16,32}.
- Backpressure: toggle i_window_ready randomly → window sequence identical to the ready=1 run; o_window stable throughout every stalled cycle.
- Full stall: drive NUM_LB=4 lines with i_window_ready=0 → o_data_ready drops after the 4th line completes; it returns to 1 within 2 cycles after the o_intr pulse.
- Full-size run (512×512, DATA_W=8, KSIZE=3) plus 2 zero lines → exactly 512*510 windows emitted and 512 o_intr pulses.

Source files
------------

// File: rtl/line_window_gen.sv
// Line-buffer ring plus KSIZE x KSIZE sliding-window generator with output
// backpressure, optional horizontal zero padding and a per-line release pulse.
module line_window_gen #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned IMG_WIDTH = 512,
    parameter int unsigned KSIZE     = 3,
    parameter int unsigned NUM_LB    = KSIZE + 1,
    parameter int unsigned PAD_EN    = 0
) (
    input  logic                          axi_clk,
    input  logic                          axi_reset_n,
    input  logic                          i_data_valid,
    input  logic [DATA_W-1:0]             i_data,
    output logic                          o_data_ready,
    output logic                          o_window_valid,
    output logic [KSIZE*KSIZE*DATA_W-1:0] o_window,
    input  logic                          i_window_ready,
    output logic                          o_intr
);

    localparam int unsigned PAD   = (PAD_EN != 0) ? (KSIZE - 1) / 2 : 0;
    localparam int unsigned NCOLS = IMG_WIDTH + 2 * PAD;
    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned RC_W  = $clog2(NCOLS + 1);
    localparam int unsigned LB_W  = (NUM_LB > 1) ? $clog2(NUM_LB) : 1;
    localparam int unsigned FL_W  = $clog2(NUM_LB + 1);
    localparam int unsigned LD_W  = $clog2(KSIZE + 1);
    localparam int unsigned WIN_W = KSIZE * KSIZE * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_LINE = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [DATA_W-1:0]  r_mem [NUM_LB][IMG_WIDTH];

    logic [COL_W-1:0]   r_wr_col;
    logic [LB_W-1:0]    r_wr_lb;
    logic [FL_W-1:0]    r_filled;
    logic               r_data_ready;

    logic [LB_W-1:0]    r_rd_lb;
    logic [RC_W-1:0]    r_rd_col;
    logic [LD_W-1:0]    r_loaded;
    logic [WIN_W-1:0]   r_window;
    logic               r_window_valid;
    logic               r_intr;

    logic               w_accept;
    logic               w_wr_done;
    logic               w_release;
    logic [FL_W-1:0]    w_filled_next;
    logic               w_stall;
    logic               w_issue;
    logic               w_last_acc;
    int                 w_dc;
    logic               w_in_img;
    logic [COL_W-1:0]   w_img_col;
    logic [WIN_W-1:0]   w_window_next;

    assign o_data_ready   = r_data_ready;
    assign o_window_valid = r_window_valid;
    assign o_window       = r_window;
    assign o_intr         = r_intr;

    assign w_accept  = i_data_valid && r_data_ready;
    assign w_wr_done = w_accept && (r_wr_col == COL_W'(IMG_WIDTH - 1));
    assign w_release = (r_state == ST_RELEASE);
    assign w_stall   = r_window_valid && !i_window_ready;

    // Line storage; contents are not reset
    always_ff @(posedge axi_clk) begin
        if (w_accept) begin
            r_mem[r_wr_lb][r_wr_col] <= i_data;
        end
    end

    // Occupancy: a completed write and a release in the same cycle cancel
    always_comb begin
        w_filled_next = r_filled;
        if (w_wr_done && !w_release) begin
            w_filled_next = r_filled + FL_W'(1);
        end else if (!w_wr_done && w_release) begin
            w_filled_next = r_filled - FL_W'(1);
        end
    end

    // Write pointer, occupancy and input ready
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_wr_col     <= '0;
            r_wr_lb      <= '0;
            r_filled     <= '0;
            r_data_ready <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_wr_done) begin
                    r_wr_col <= '0;
                    r_wr_lb  <= (r_wr_lb == LB_W'(NUM_LB - 1)) ? '0 : r_wr_lb + LB_W'(1);
                end else begin
                    r_wr_col <= r_wr_col + COL_W'(1);
                end
            end
            r_filled     <= w_filled_next;
            r_data_ready <= (w_filled_next < FL_W'(NUM_LB));
        end
    end

    // Read FSM state register
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Read FSM next state and per-cycle column issue
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_last_acc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_filled >= FL_W'(KSIZE)) begin
                    w_next_state = ST_RD_LINE;
                end
            end
            ST_RD_LINE: begin
                if (!w_stall) begin
                    if (r_rd_col < RC_W'(NCOLS)) begin
                        w_issue = 1'b1;
                    end else if (r_window_valid) begin
                        w_last_acc   = 1'b1;
                        w_next_state = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Next window: shift left one column and read the new column into c=KSIZE-1
    always_comb begin
        w_window_next = '0;
        w_dc          = int'(r_rd_col) - int'(PAD);
        w_in_img      = (w_dc >= 0) && (w_dc < int'(IMG_WIDTH));
        w_img_col     = COL_W'(w_dc);
        for (int r = 0; r < int'(KSIZE); r++) begin
            for (int c = 0; c < int'(KSIZE) - 1; c++) begin
                w_window_next[(r*KSIZE + c)*DATA_W +: DATA_W] =
                    r_window[(r*KSIZE + c + 1)*DATA_W +: DATA_W];
            end
            if (w_in_img) begin
                w_window_next[(r*KSIZE + KSIZE - 1)*DATA_W +: DATA_W] =
                    r_mem[LB_W'((int'(r_rd_lb) + r) % int'(NUM_LB))][w_img_col];
            end
        end
    end

    // Read datapath: column counter, window register, valid and release pulse
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_rd_lb        <= '0;
            r_rd_col       <= '0;
            r_loaded       <= '0;
            r_window       <= '0;
            r_window_valid <= 1'b0;
            r_intr         <= 1'b0;
        end else begin
            r_intr <= (w_next_state == ST_RELEASE);
            if (r_state == ST_IDLE) begin
                r_rd_col       <= '0;
                r_loaded       <= '0;
                r_window       <= '0;
                r_window_valid <= 1'b0;
            end else if (w_issue) begin
                r_window       <= w_window_next;
                r_rd_col       <= r_rd_col + RC_W'(1);
                if (r_loaded < LD_W'(KSIZE)) begin
                    r_loaded <= r_loaded + LD_W'(1);
                end
                r_window_valid <= (r_loaded >= LD_W'(KSIZE - 1));
            end else if (w_last_acc) begin
                r_window_valid <= 1'b0;
            end
            if (w_release) begin
                r_rd_lb <= (r_rd_lb == LB_W'(NUM_LB - 1)) ? '0 : r_rd_lb + LB_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_line_window_gen.sv
// Scoreboard bench: two instances (no padding / padding) on an 8-pixel-wide image.
module tb_line_window_gen;

    localparam int W     = 8;
    localparam int K     = 3;
    localparam int NLB   = K + 1;
    localparam int NL    = 16;
    localparam int WIN_W = K * K * 8;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input int inst, input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL [pad%0d] %s: got %h want %h (cycle %0d)", inst, nm, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int PAD = (g != 0) ? (K - 1) / 2 : 0;
        localparam int NW  = (g != 0) ? W : W - K + 1;

        logic             dv;
        logic [7:0]       di;
        logic             dr;
        logic             wv;
        logic [WIN_W-1:0] win;
        logic             wr;
        logic             intr;

        line_window_gen #(
            .DATA_W   (8),
            .IMG_WIDTH(W),
            .KSIZE    (K),
            .NUM_LB   (NLB),
            .PAD_EN   (g)
        ) u_dut (
            .axi_clk       (clk),
            .axi_reset_n   (rst_n),
            .i_data_valid  (dv),
            .i_data        (di),
            .o_data_ready  (dr),
            .o_window_valid(wv),
            .o_window      (win),
            .i_window_ready(wr),
            .o_intr        (intr)
        );

        logic [7:0]       pix [NL][W];
        logic [WIN_W-1:0] q [$];
        int  n_done_lines = 0;
        int  n_intr       = 0;
        int  n_win        = 0;
        int  t_last3      = -1000;
        int  rdy_mode     = 0;
        int  intr_age     = -1;
        bit  seen_first   = 0;
        bit  stall_prev   = 0;
        bit  intr_prev    = 0;
        logic [WIN_W-1:0] prev_win;
        bit  done         = 0;

        // Reference window: rows row0..row0+K-1, image columns w-PAD..w-PAD+K-1, zero outside
        function automatic logic [WIN_W-1:0] exp_win(input int row0, input int w);
            logic [WIN_W-1:0] v;
            v = '0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    int col;
                    col = w + c - PAD;
                    if (col >= 0 && col < W) v[(r*K + c)*8 +: 8] = pix[row0 + r][col];
                end
            end
            return v;
        endfunction

        task automatic accepted(input int k);
            int row;
            int col;
            row = k / W;
            col = k % W;
            if (col == W - 1) begin
                n_done_lines++;
                if (row == K - 1) t_last3 = cyc;
                if (row >= K - 1) begin
                    for (int w = 0; w < NW; w++) q.push_back(exp_win(row - K + 1, w));
                end
            end
        endtask

        // Offer pixel k until accepted or maxw cycles pass; entered and left at posedge+1
        task automatic push(input int k, input int pct, input int maxw, output bit ok);
            int waited;
            waited = 0;
            ok = 0;
            while (!ok && waited < maxw) begin
                dv = ($urandom_range(99) < pct);
                di = dv ? pix[k / W][k % W] : 8'($urandom);
                case (rdy_mode)
                    0:       wr = 1'b1;
                    1:       wr = 1'($urandom_range(1));
                    default: wr = 1'b0;
                endcase
                @(negedge clk);
                if (dv && dr) begin
                    ok = 1;
                    accepted(k);
                end
                @(posedge clk);
                #1;
                waited++;
            end
            dv = 1'b0;
        endtask

        initial begin
            int k;
            bit ok;
            dv = 1'b0;
            di = '0;
            wr = 1'b1;
            for (int r = 0; r < NL; r++)
                for (int c = 0; c < W; c++)
                    pix[r][c] = (r < 5) ? 8'(16 * r + c) : 8'($urandom);

            @(negedge clk);
            chk(g, "rst_ready", dr, 0);
            chk(g, "rst_valid", wv, 0);
            chk(g, "rst_window", win, 0);
            chk(g, "rst_intr", intr, 0);
            wait (rst_n);
            #1;
            chk(g, "ready_at_release", dr, 0);
            @(negedge clk);
            chk(g, "ready_after_release", dr, 1);
            @(posedge clk);
            #1;

            // Ramp lines, continuous input, downstream always ready
            rdy_mode = 0;
            for (k = 0; k < 5 * W; k++) begin
                push(k, 100, 200, ok);
                chk(g, "accept_p1", ok, 1);
            end
            // Random input gaps and random backpressure
            rdy_mode = 1;
            for (k = 5 * W; k < 10 * W; k++) begin
                push(k, 70, 400, ok);
                chk(g, "accept_p2", ok, 1);
            end
            // Downstream blocked until the ring fills
            rdy_mode = 2;
            for (k = 10 * W; k < NL * W; k++) begin
                push(k, 100, 40, ok);
                if (!ok) break;
            end
            chk(g, "held_lines", n_done_lines - n_intr, NLB);
            chk(g, "ready_low_full", dr, 0);
            rdy_mode = 0;
            for (; k < NL * W; k++) begin
                push(k, 100, 200, ok);
                chk(g, "accept_p3", ok, 1);
            end
            wr = 1'b1;
            for (int i = 0; i < 1000 && n_intr < NL - K + 1; i++) @(negedge clk);
            repeat (20) @(negedge clk);
            chk(g, "intr_count", n_intr, NL - K + 1);
            chk(g, "win_count", n_win, (NL - K + 1) * NW);
            chk(g, "sb_left", q.size(), 0);
            chk(g, "ready_end", dr, 1);
            done = 1;
        end

        // Monitor: scoreboard pop, hold stability, interrupt rules, first-window latency
        always @(negedge clk) begin
            if (rst_n) begin
                if (stall_prev) begin
                    chk(g, "hold_valid", wv, 1);
                    chk(g, "hold_window", win, prev_win);
                end
                if (wv && !seen_first) begin
                    seen_first = 1;
                    chk(g, "first_win_latency", cyc - t_last3, K + 2);
                end
                if (wv && wr) begin
                    chk(g, "win_expected", q.size() != 0, 1);
                    if (q.size() != 0) chk(g, "window", win, q.pop_front());
                    n_win++;
                end
                if (intr_age >= 0) begin
                    intr_age++;
                    if (intr_age == 2) begin
                        chk(g, "ready_after_intr", dr, 1);
                        intr_age = -1;
                    end
                end
                if (intr) begin
                    chk(g, "intr_pulse", intr_prev, 0);
                    chk(g, "intr_lines_ok", n_done_lines >= K + n_intr, 1);
                    n_intr++;
                    intr_age = 0;
                end
                stall_prev = wv && !wr;
                prev_win   = win;
                intr_prev  = intr;
            end
        end
    end

    initial begin
        bit fin;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        fin = 0;
        for (int i = 0; i < 30000; i++) begin
            if (g_inst[0].done && g_inst[1].done) begin
                fin = 1;
                break;
            end
            @(posedge clk);
        end
        total++;
        if (!fin) begin
            bad++;
            $display("FAIL timeout: run did not complete within cycle budget");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
